fifo_flow_control_unit: RTL and testbench

FIFO_FLOW_CONTROL_UNIT -- requirements
Module: fifo_flow_control_unit

---
 rtl/fifo_flow_control_unit_if.sv | 37 +++
 rtl/fifo_flow_control_unit.sv | 90 +++++++++
 tb/tb_fifo_flow_control_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fifo_flow_control_unit_if.sv
// Handshake and status bundle between a FIFO storage array and its flow-control unit.
// The master side issues push/pop/clear requests; the slave side returns acks, pointers and flags.
interface fifo_flow_control_unit_if #(
   parameter int BUFFER_DEPTH = 8
);
   localparam int ADDR_WIDTH  = $clog2(BUFFER_DEPTH);
   localparam int COUNT_WIDTH = $clog2(BUFFER_DEPTH + 1);

   logic                   write_strobe_din;
   logic                   read_strobe_din;
   logic                   error_clear_din;
   logic                   write_ack_dout;
   logic                   read_ack_dout;
   logic [ADDR_WIDTH-1:0]  write_addr_dout;
   logic [ADDR_WIDTH-1:0]  read_addr_dout;
   logic [COUNT_WIDTH-1:0] count_dout;
   logic                   full_dout;
   logic                   empty_dout;
   logic                   almost_full_dout;
   logic                   almost_empty_dout;
   logic                   overflow_dout;
   logic                   underflow_dout;

   modport master (
      output write_strobe_din, read_strobe_din, error_clear_din,
      input  write_ack_dout, read_ack_dout, write_addr_dout, read_addr_dout,
      input  count_dout, full_dout, empty_dout, almost_full_dout, almost_empty_dout,
      input  overflow_dout, underflow_dout
   );

   modport slave (
      input  write_strobe_din, read_strobe_din, error_clear_din,
      output write_ack_dout, read_ack_dout, write_addr_dout, read_addr_dout,
      output count_dout, full_dout, empty_dout, almost_full_dout, almost_empty_dout,
      output overflow_dout, underflow_dout
   );
endinterface

// File: rtl/fifo_flow_control_unit.sv
// FIFO pointer/occupancy controller: accepts push/pop requests, wraps pointers at BUFFER_DEPTH,
// and keeps registered level flags plus sticky overflow/underflow flags.
module fifo_flow_control_unit #(
   parameter int BUFFER_DEPTH       = 8,
   parameter int ALMOST_FULL_LEVEL  = BUFFER_DEPTH - 1,
   parameter int ALMOST_EMPTY_LEVEL = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   fifo_flow_control_unit_if.slave bus
);
   localparam int ADDR_WIDTH  = $clog2(BUFFER_DEPTH);
   localparam int COUNT_WIDTH = $clog2(BUFFER_DEPTH + 1);

   localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(BUFFER_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] DEPTH_C   = COUNT_WIDTH'(BUFFER_DEPTH);
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
   localparam logic                   AF_RESET  = (0 >= ALMOST_FULL_LEVEL);
   localparam logic                   AE_RESET  = (0 <= ALMOST_EMPTY_LEVEL);

   logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   full_q, empty_q, almost_full_q, almost_empty_q;
   logic                   overflow_q, overflow_d;
   logic                   underflow_q, underflow_d;
   logic                   push, pop;

   always_comb begin
      // Acks are forced low while reset is held so the storage array never sees a stray write.
      pop  = !reset && bus.read_strobe_din && !empty_q;
      push = !reset && bus.write_strobe_din && (!full_q || pop);

      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_ONE;

      rd_ptr_d = rd_ptr_q;
      if (pop) rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_ONE;

      count_d = count_q;
      if (push && !pop)      count_d = count_q + COUNT_ONE;
      else if (pop && !push) count_d = count_q - COUNT_ONE;

      // Set beats clear when both happen in the same cycle.
      overflow_d = overflow_q;
      if (bus.write_strobe_din && !push) overflow_d = 1'b1;
      else if (bus.error_clear_din)      overflow_d = 1'b0;

      underflow_d = underflow_q;
      if (bus.read_strobe_din && !pop) underflow_d = 1'b1;
      else if (bus.error_clear_din)    underflow_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= AF_RESET;
         almost_empty_q <= AE_RESET;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         full_q         <= (count_d == DEPTH_C);
         empty_q        <= (count_d == '0);
         almost_full_q  <= (int'(count_d) >= ALMOST_FULL_LEVEL);
         almost_empty_q <= (int'(count_d) <= ALMOST_EMPTY_LEVEL);
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   assign bus.write_ack_dout    = push;
   assign bus.read_ack_dout     = pop;
   assign bus.write_addr_dout   = wr_ptr_q;
   assign bus.read_addr_dout    = rd_ptr_q;
   assign bus.count_dout        = count_q;
   assign bus.full_dout         = full_q;
   assign bus.empty_dout        = empty_q;
   assign bus.almost_full_dout  = almost_full_q;
   assign bus.almost_empty_dout = almost_empty_q;
   assign bus.overflow_dout     = overflow_q;
   assign bus.underflow_dout    = underflow_q;
endmodule

// File: tb/tb_fifo_flow_control_unit.sv
// Bench for fifo_flow_control_unit (depth 5): directed corner cases plus random traffic
// compared each cycle against a queue-based occupancy model.
module tb_fifo_flow_control_unit;
   localparam int DEPTH = 5;
   localparam int AF    = 4;
   localparam int AE    = 1;

   logic clk;
   logic reset;

   fifo_flow_control_unit_if #(.BUFFER_DEPTH(DEPTH)) bus ();

   fifo_flow_control_unit #(
      .BUFFER_DEPTH      (DEPTH),
      .ALMOST_FULL_LEVEL (AF),
      .ALMOST_EMPTY_LEVEL(AE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   // Model: the queue holds the sequence numbers of stored entries; pointers are
   // total accepted pushes/pops modulo the depth.
   int  mq[$];
   int  n_push, n_pop;
   bit  m_ovf, m_unf;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      n_push = 0;
      n_pop  = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic check_state(input string ph);
      int sz;
      sz = mq.size();
      chk({ph, ".count"},  int'(bus.count_dout),        sz);
      chk({ph, ".waddr"},  int'(bus.write_addr_dout),   n_push % DEPTH);
      chk({ph, ".raddr"},  int'(bus.read_addr_dout),    n_pop % DEPTH);
      chk({ph, ".full"},   int'(bus.full_dout),         int'(sz == DEPTH));
      chk({ph, ".empty"},  int'(bus.empty_dout),        int'(sz == 0));
      chk({ph, ".afull"},  int'(bus.almost_full_dout),  int'(sz >= AF));
      chk({ph, ".aempty"}, int'(bus.almost_empty_dout), int'(sz <= AE));
      chk({ph, ".ovf"},    int'(bus.overflow_dout),     int'(m_ovf));
      chk({ph, ".unf"},    int'(bus.underflow_dout),    int'(m_unf));
   endtask

   // Called #1 after a rising edge; drives one cycle of requests and checks acks and the next state.
   task automatic step(input string ph, input bit w, input bit r, input bit c);
      bit e_pop, e_push;
      bus.write_strobe_din = w;
      bus.read_strobe_din  = r;
      bus.error_clear_din  = c;
      #1;
      e_pop  = r && (mq.size() > 0);
      e_push = w && ((mq.size() < DEPTH) || e_pop);
      chk({ph, ".wack"}, int'(bus.write_ack_dout), int'(e_push));
      chk({ph, ".rack"}, int'(bus.read_ack_dout),  int'(e_pop));
      @(posedge clk);
      #1;
      if (e_pop) begin
         void'(mq.pop_front());
         n_pop++;
      end
      if (e_push) begin
         mq.push_back(n_push);
         n_push++;
      end
      if (w && !e_push)  m_ovf = 1'b1;
      else if (c)        m_ovf = 1'b0;
      if (r && !e_pop)   m_unf = 1'b1;
      else if (c)        m_unf = 1'b0;
      check_state(ph);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit w, r;
      checks = 0;
      errors = 0;
      bus.write_strobe_din = 1'b0;
      bus.read_strobe_din  = 1'b0;
      bus.error_clear_din  = 1'b0;
      reset = 1'b1;
      model_reset();
      #2;
      check_state("rst");
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 5; i++) step("fill", 1'b1, 1'b0, 1'b0);
      step("ovf", 1'b1, 1'b0, 1'b0);
      step("clr1", 1'b0, 1'b0, 1'b1);
      step("fullpp", 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step("drain", 1'b0, 1'b1, 1'b0);
      step("emptypp", 1'b1, 1'b1, 1'b0);
      step("clr2", 1'b0, 1'b0, 1'b1);
      step("setclr", 1'b0, 1'b1, 1'b1);
      step("setclr2", 1'b0, 1'b1, 1'b1);
      step("clr3", 1'b0, 1'b0, 1'b1);

      // Occupancy held inside 1..4 so both pointers wrap repeatedly.
      for (int i = 0; i < 24; i++) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         if (mq.size() <= 1) w = 1'b1;
         if (mq.size() <= 1 && !r) r = 1'b0;
         if (mq.size() >= 4) r = 1'b1;
         step("band", w, r, 1'b0);
      end

      for (int i = 0; i < 300; i++)
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0));

      // Bring occupancy to 3 and hit reset between edges.
      while (mq.size() < 3) step("pre", 1'b1, 1'b0, 1'b0);
      while (mq.size() > 3) step("pre", 1'b0, 1'b1, 1'b0);
      step("pre_ovf", 1'b0, 1'b0, 1'b0);
      bus.write_strobe_din = 1'b1;
      bus.read_strobe_din  = 1'b1;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_state("arst");
      chk("arst.wack", int'(bus.write_ack_dout), 0);
      chk("arst.rack", int'(bus.read_ack_dout),  0);
      @(posedge clk);
      #1;
      check_state("arst_hold");
      reset = 1'b0;

      step("post", 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 150; i++)
         step("rand2", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
